// File: rtl/cpu_seq_pkg.sv
// cpu_seq_pkg: shared state encoding, default latencies and wait-counter sizing for cpu_sequencer.
package cpu_seq_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, EXEC, MEMWAIT, DONE} seq_state_t;
  localparam int DEF_IMEM_LAT = 1;
  localparam int DEF_MEM_LAT = 0;
  function automatic int wait_cnt_w(input int imem_lat, input int mem_lat);
    int m = imem_lat > mem_lat ? imem_lat : mem_lat;
    return m > 1 ? $clog2(m) : 1;
  endfunction
endpackage

// File: rtl/cpu_sequencer_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear and enable.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);
  always_ff @(posedge clk)
    if (reset || clr) count <= '0;
    else if (en && count != '1) count <= count + 1'b1;
endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle run control (fetch/exec/memwait) with PC, IR and perf counters.
// Optional watchdog enabled by defining SEQ_WATCHDOG_EN.
module cpu_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int PC_W = 10,
  parameter int INSTR_W = 9,
  parameter int IMEM_LAT = DEF_IMEM_LAT,
  parameter int MEM_LAT = DEF_MEM_LAT,
  parameter int CNT_W = 16,
  parameter logic [CNT_W-1:0] WDOG_LIMIT = '1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               done,
  output logic [PC_W-1:0]    pc,
  input  logic [INSTR_W-1:0] instr_in,
  output logic [INSTR_W-1:0] instr,
  output logic               exec_en,
  input  logic               halt,
  input  logic               mem_req,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  output logic               mem_busy,
  output logic               timeout,
  output logic [CNT_W-1:0]   cycle_count,
  output logic [CNT_W-1:0]   instr_count
);
  localparam int WAIT_W = wait_cnt_w(IMEM_LAT, MEM_LAT);
  localparam logic [WAIT_W-1:0] FETCH_END = WAIT_W'(IMEM_LAT - 1);
  localparam logic [WAIT_W-1:0] MEM_END = WAIT_W'(MEM_LAT > 0 ? MEM_LAT - 1 : 0);
  localparam bit HAS_MEMWAIT = MEM_LAT > 0;

  seq_state_t state, nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [PC_W-1:0] pend_pc, next_pc;
  logic fetch_end, mem_end, running, launch, wdog;

  assign launch = state == IDLE && start;
  assign running = state == FETCH || state == EXEC || state == MEMWAIT;
  assign fetch_end = state == FETCH && wait_cnt == FETCH_END;
  assign mem_end = state == MEMWAIT && wait_cnt == MEM_END;
  assign next_pc = branch_taken ? branch_target : pc + 1'b1;

`ifdef SEQ_WATCHDOG_EN
  // fires on the running cycle that brings cycle_count up to the limit
  assign wdog = running && cycle_count >= WDOG_LIMIT - 1'b1;
  always_ff @(posedge clk)
    if (reset || launch) timeout <= 1'b0;
    else if (wdog) timeout <= 1'b1;
`else
  logic unused_wdog;
  assign wdog = 1'b0;
  assign timeout = 1'b0;
  assign unused_wdog = ^WDOG_LIMIT;
`endif

  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= nxt;

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    nxt = start ? FETCH : IDLE;
      FETCH:   nxt = fetch_end ? EXEC : FETCH;
      EXEC:    nxt = halt ? DONE : (mem_req && HAS_MEMWAIT) ? MEMWAIT : FETCH;
      MEMWAIT: nxt = mem_end ? FETCH : MEMWAIT;
      DONE:    nxt = start ? DONE : IDLE;
      default: nxt = IDLE;
    endcase
    if (wdog) nxt = DONE;
  end

  always_comb begin
    exec_en = state == EXEC;
    mem_busy = state == MEMWAIT;
    done = state == DONE;
  end

  // wait counter is shared by FETCH and MEMWAIT and restarts on every state change
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
      pc <= '0;
      pend_pc <= '0;
      instr <= '0;
    end else begin
      wait_cnt <= (state == nxt && (state == FETCH || state == MEMWAIT)) ? wait_cnt + 1'b1 : '0;
      if (launch) pc <= '0;
      if (fetch_end) instr <= instr_in;
      if (state == EXEC && !halt && !wdog) begin
        if (mem_req && HAS_MEMWAIT) pend_pc <= next_pc;
        else pc <= next_pc;
      end
      if (mem_end && !wdog) pc <= pend_pc;
    end
  end

  sat_counter #(.W(CNT_W)) u_cycle_count (
    .clk(clk), .reset(reset), .clr(launch), .en(running), .count(cycle_count)
  );

  sat_counter #(.W(CNT_W)) u_instr_count (
    .clk(clk), .reset(reset), .clr(launch), .en(state == EXEC), .count(instr_count)
  );
endmodule
